async_operator_fifo: RTL and testbench

//  Next-gen dataflow node for the arf graph: joins INPUT_SIZE req/ack operand channels,

---
 rtl/async_operator_fifo.sv | 193 +++++++++++++++++++
 tb/tb_async_operator_fifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_operator_fifo.sv
// Dataflow node: joins INPUT_SIZE req/ack operand lanes, applies OP and buffers results for
// OUTPUT_SIZE independently paced readers. Define ASYNC_OP_STATS_EN to add fire/stall counters.
module async_operator_fifo #(
  parameter int    DATA_WIDTH  = 32,
  parameter int    INPUT_SIZE  = 2,
  parameter int    OUTPUT_SIZE = 2,
  parameter int    FIFO_DEPTH  = 4,
  parameter string OP          = "add",
  parameter int    IMMEDIATE   = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [INPUT_SIZE-1:0]             req_l,
  input  logic [INPUT_SIZE-1:0]             ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0]  din,
  input  logic [OUTPUT_SIZE-1:0]            req_r,
  output logic [OUTPUT_SIZE-1:0]            ack_r,
  output logic [DATA_WIDTH*OUTPUT_SIZE-1:0] dout,
  output logic [$clog2(FIFO_DEPTH):0]       occupancy
`ifdef ASYNC_OP_STATS_EN
  ,
  output logic [31:0]                       fire_count,
  output logic [31:0]                       stall_count
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;

  typedef enum logic [2:0] {
    OP_PASS, OP_ADDI, OP_SUBI, OP_MULI, OP_ADD, OP_SUB, OP_MUL
  } op_e;

  localparam op_e OP_SEL = (OP == "addi") ? OP_ADDI :
                           (OP == "subi") ? OP_SUBI :
                           (OP == "muli") ? OP_MULI :
                           (OP == "add")  ? OP_ADD  :
                           (OP == "sub")  ? OP_SUB  :
                           (OP == "mul")  ? OP_MUL  : OP_PASS;

  logic [INPUT_SIZE-1:0]  req_l_q, req_l_d, has_q, has_d;
  logic [DATA_WIDTH-1:0]  opnd_q [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]  opnd_d [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]  fifo_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_d [FIFO_DEPTH];
  logic [OUTPUT_SIZE-1:0] pending_q [FIFO_DEPTH];
  logic [OUTPUT_SIZE-1:0] pending_d [FIFO_DEPTH];
  logic [PW-1:0]          rd_ptr_q [OUTPUT_SIZE];
  logic [PW-1:0]          rd_ptr_d [OUTPUT_SIZE];
  logic [DATA_WIDTH-1:0]  dout_q [OUTPUT_SIZE];
  logic [DATA_WIDTH-1:0]  dout_d [OUTPUT_SIZE];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, head_ptr_q, head_ptr_d;
  logic [OW-1:0]          occ_q, occ_d;
  logic [OUTPUT_SIZE-1:0] ack_r_q, ack_r_d;
  logic [DATA_WIDTH-1:0]  result_s;
  logic                   fire_s, retire_s;

  // Operator datapath over the held operands; arithmetic wraps at DATA_WIDTH.
  always_comb begin
    result_s = opnd_q[0];
    case (OP_SEL)
      OP_ADDI: result_s = opnd_q[0] + DATA_WIDTH'(IMMEDIATE);
      OP_SUBI: result_s = opnd_q[0] - DATA_WIDTH'(IMMEDIATE);
      OP_MULI: result_s = opnd_q[0] * DATA_WIDTH'(IMMEDIATE);
      OP_ADD:  for (int i = 1; i < INPUT_SIZE; i++) result_s = result_s + opnd_q[i];
      OP_SUB:  for (int i = 1; i < INPUT_SIZE; i++) result_s = result_s - opnd_q[i];
      OP_MUL:  for (int i = 1; i < INPUT_SIZE; i++) result_s = result_s * opnd_q[i];
      default: result_s = opnd_q[0];
    endcase
  end

  // Next-state: operand capture, fire into the buffer, per-output reads and head retire.
  always_comb begin
    req_l_d    = req_l_q;
    has_d      = has_q;
    opnd_d     = opnd_q;
    fifo_d     = fifo_q;
    pending_d  = pending_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    wr_ptr_d   = wr_ptr_q;
    head_ptr_d = head_ptr_q;
    occ_d      = occ_q;
    ack_r_d    = {OUTPUT_SIZE{1'b0}};
    // Full is judged on registered occupancy, so a slot freed this cycle is not reused yet.
    fire_s     = (&has_q) && (occ_q < OW'(FIFO_DEPTH));
    retire_s   = (occ_q != {OW{1'b0}}) && (pending_q[head_ptr_q] == {OUTPUT_SIZE{1'b0}});

    for (int i = 0; i < INPUT_SIZE; i++) begin
      if (ack_l[i] && req_l_q[i]) begin
        opnd_d[i]  = din[DATA_WIDTH*i +: DATA_WIDTH];
        has_d[i]   = 1'b1;
        req_l_d[i] = 1'b0;
      end else if (fire_s) begin
        has_d[i]   = 1'b0;
        req_l_d[i] = 1'b0;
      end else begin
        req_l_d[i] = ~has_q[i];
      end
    end

    if (fire_s) begin
      fifo_d[wr_ptr_q]    = result_s;
      pending_d[wr_ptr_q] = {OUTPUT_SIZE{1'b1}};
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    for (int j = 0; j < OUTPUT_SIZE; j++) begin
      if (req_r[j] && !ack_r_q[j] && pending_q[rd_ptr_q[j]][j]) begin
        ack_r_d[j]                  = 1'b1;
        dout_d[j]                   = fifo_q[rd_ptr_q[j]];
        pending_d[rd_ptr_q[j]][j]   = 1'b0;
        rd_ptr_d[j]                 = rd_ptr_q[j] + PW'(1);
      end else begin
        ack_r_d[j] = 1'b0;
      end
    end

    if (retire_s) begin
      head_ptr_d = head_ptr_q + PW'(1);
    end else begin
      head_ptr_d = head_ptr_q;
    end

    case ({fire_s, retire_s})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_l_q    <= {INPUT_SIZE{1'b0}};
      has_q      <= {INPUT_SIZE{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      head_ptr_q <= {PW{1'b0}};
      occ_q      <= {OW{1'b0}};
      ack_r_q    <= {OUTPUT_SIZE{1'b0}};
      for (int i = 0; i < INPUT_SIZE; i++) opnd_q[i] <= {DATA_WIDTH{1'b0}};
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_q[k]    <= {DATA_WIDTH{1'b0}};
        pending_q[k] <= {OUTPUT_SIZE{1'b0}};
      end
      for (int j = 0; j < OUTPUT_SIZE; j++) begin
        rd_ptr_q[j] <= {PW{1'b0}};
        dout_q[j]   <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      req_l_q    <= req_l_d;
      has_q      <= has_d;
      opnd_q     <= opnd_d;
      fifo_q     <= fifo_d;
      pending_q  <= pending_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      wr_ptr_q   <= wr_ptr_d;
      head_ptr_q <= head_ptr_d;
      occ_q      <= occ_d;
      ack_r_q    <= ack_r_d;
    end
  end

  // Pack per-output result registers onto the flat bus.
  always_comb begin
    dout = {(DATA_WIDTH*OUTPUT_SIZE){1'b0}};
    for (int j = 0; j < OUTPUT_SIZE; j++) dout[DATA_WIDTH*j +: DATA_WIDTH] = dout_q[j];
  end

  assign req_l     = req_l_q;
  assign ack_r     = ack_r_q;
  assign occupancy = occ_q;

`ifdef ASYNC_OP_STATS_EN
  logic [31:0] fire_cnt_q, stall_cnt_q;

  // Fire and full-stall event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_cnt_q  <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (fire_s) fire_cnt_q <= fire_cnt_q + 32'd1;
      if ((&has_q) && (occ_q == OW'(FIFO_DEPTH))) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fire_count  = fire_cnt_q;
  assign stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_async_operator_fifo.sv
// Self-checking bench for async_operator_fifo: add, addi, mul and sub instances share clk/rst;
// a queue model per output channel predicts every ack_r/dout in fire order.
module tb_async_operator_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // add: IN=2 OUT=2
  logic [1:0]  add_req_l, add_ack_l = 2'b00, add_req_r = 2'b00, add_ack_r;
  logic [63:0] add_din = 64'd0, add_dout;
  logic [2:0]  add_occ;
  // addi (IMMEDIATE=2): IN=1 OUT=2
  logic [0:0]  addi_req_l, addi_ack_l = 1'b0;
  logic [31:0] addi_din = 32'd0;
  logic [1:0]  addi_req_r = 2'b00, addi_ack_r;
  logic [63:0] addi_dout;
  logic [2:0]  addi_occ;
  // mul and sub: IN=2 OUT=1
  logic [1:0]  mul_req_l, sub_req_l, ms_ack_l = 2'b00;
  logic [63:0] mul_din = 64'd0, sub_din = 64'd0;
  logic [0:0]  ms_req_r = 1'b0, mul_ack_r, sub_ack_r;
  logic [31:0] mul_dout, sub_dout;
  logic [2:0]  mul_occ, sub_occ;
`ifdef ASYNC_OP_STATS_EN
  logic [31:0] fc [4];
  logic [31:0] sc [4];
`endif

  async_operator_fifo #(.OP("add")) u_add (
    .clk(clk), .rst(rst), .req_l(add_req_l), .ack_l(add_ack_l), .din(add_din),
    .req_r(add_req_r), .ack_r(add_ack_r), .dout(add_dout), .occupancy(add_occ)
`ifdef ASYNC_OP_STATS_EN
    , .fire_count(fc[0]), .stall_count(sc[0])
`endif
  );
  async_operator_fifo #(.INPUT_SIZE(1), .OP("addi"), .IMMEDIATE(2)) u_addi (
    .clk(clk), .rst(rst), .req_l(addi_req_l), .ack_l(addi_ack_l), .din(addi_din),
    .req_r(addi_req_r), .ack_r(addi_ack_r), .dout(addi_dout), .occupancy(addi_occ)
`ifdef ASYNC_OP_STATS_EN
    , .fire_count(fc[1]), .stall_count(sc[1])
`endif
  );
  async_operator_fifo #(.OUTPUT_SIZE(1), .OP("mul")) u_mul (
    .clk(clk), .rst(rst), .req_l(mul_req_l), .ack_l(ms_ack_l), .din(mul_din),
    .req_r(ms_req_r), .ack_r(mul_ack_r), .dout(mul_dout), .occupancy(mul_occ)
`ifdef ASYNC_OP_STATS_EN
    , .fire_count(fc[2]), .stall_count(sc[2])
`endif
  );
  async_operator_fifo #(.OUTPUT_SIZE(1), .OP("sub")) u_sub (
    .clk(clk), .rst(rst), .req_l(sub_req_l), .ack_l(ms_ack_l), .din(sub_din),
    .req_r(ms_req_r), .ack_r(sub_ack_r), .dout(sub_dout), .occupancy(sub_occ)
`ifdef ASYNC_OP_STATS_EN
    , .fire_count(fc[3]), .stall_count(sc[3])
`endif
  );

  // Model: channel 0/1 = add out0/1, 2/3 = addi out0/1, 4 = mul, 5 = sub.
  logic [31:0] exp_q [6][$];
  int          ack_cnt [6];
  logic [31:0] last_dout [6];

  // Compare process: every ack_r pulse must be isolated and carry the next expected result.
  initial begin
    logic [5:0]  ack_v;
    logic [5:0]  prev_ack;
    logic [31:0] dv [6];
    logic [31:0] e;
    prev_ack = 6'd0;
    for (int c = 0; c < 6; c++) begin ack_cnt[c] = 0; last_dout[c] = 32'd0; end
    forever begin
      @(negedge clk);
      ack_v = {sub_ack_r, mul_ack_r, addi_ack_r, add_ack_r};
      dv[0] = add_dout[31:0];  dv[1] = add_dout[63:32];
      dv[2] = addi_dout[31:0]; dv[3] = addi_dout[63:32];
      dv[4] = mul_dout;        dv[5] = sub_dout;
      for (int c = 0; c < 6; c++) begin
        if (ack_v[c]) begin
          checks++;
          if (prev_ack[c]) begin
            failures++;
            $display("FAIL ack_back_to_back ch=%0d actual=consecutive required=gap", c);
          end else if (exp_q[c].size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack ch=%0d actual=0x%0h required=no_ack", c, dv[c]);
          end else begin
            e = exp_q[c].pop_front();
            if (dv[c] !== e) begin
              failures++;
              $display("FAIL dout ch=%0d actual=0x%0h required=0x%0h", c, dv[c], e);
            end
          end
          ack_cnt[c]++;
          last_dout[c] = dv[c];
        end
      end
      prev_ack = ack_v;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  task automatic send_add(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (add_req_l !== 2'b11 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("send_add");
    else begin
      add_ack_l = 2'b11; add_din = {b, a};
      @(negedge clk);
      add_ack_l = 2'b00;
      exp_q[0].push_back(a + b); exp_q[1].push_back(a + b);
    end
  endtask

  task automatic send_addi(input logic [31:0] a);
    int n = 0;
    while (addi_req_l !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("send_addi");
    else begin
      addi_ack_l = 1'b1; addi_din = a;
      @(negedge clk);
      addi_ack_l = 1'b0;
      exp_q[2].push_back(a + 32'd2); exp_q[3].push_back(a + 32'd2);
    end
  endtask

  task automatic send_ms(input logic [31:0] ma, input logic [31:0] mb,
                         input logic [31:0] sa, input logic [31:0] sb);
    int n = 0;
    while ((mul_req_l !== 2'b11 || sub_req_l !== 2'b11) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout("send_ms");
    else begin
      ms_ack_l = 2'b11; mul_din = {mb, ma}; sub_din = {sb, sa};
      @(negedge clk);
      ms_ack_l = 2'b00;
      exp_q[4].push_back(ma * mb); exp_q[5].push_back(sa - sb);
    end
  endtask

  function automatic bit idle();
    bit r = (add_occ == 3'd0) && (addi_occ == 3'd0) && (mul_occ == 3'd0) && (sub_occ == 3'd0);
    for (int c = 0; c < 6; c++) if (exp_q[c].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while (!idle() && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) timeout(name);
    else chk(name, 32'(add_occ), 32'd0);
  endtask

  initial begin
    int b0, b1;
    // 1: reset held two cycles
    @(negedge clk);
    chk("rst_req_l_c1", 32'(add_req_l), 32'd0);
    chk("rst_ack_r_c1", 32'(add_ack_r), 32'd0);
    @(negedge clk);
    chk("rst_req_l_c2", 32'(add_req_l), 32'd0);
    chk("rst_occ_c2", 32'(add_occ), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("req_l_after_rst", 32'(add_req_l), 32'd3);
    chk("occ_after_rst", 32'(add_occ), 32'd0);

    // 2: add 5+7, both outputs requesting
    add_req_r = 2'b11;
    send_add(32'd5, 32'd7);
    drain("drain_add_single");
    chk("add_acks_out0", 32'(ack_cnt[0]), 32'd1);
    chk("add_acks_out1", 32'(ack_cnt[1]), 32'd1);
    chk("add_value_out0", last_dout[0], 32'd12);
    chk("add_value_out1", last_dout[1], 32'd12);
`ifdef ASYNC_OP_STATS_EN
    chk("fire_count_one", fc[0], 32'd1);
`endif

    // 3: stream 0..5 with out1 idle, then release out1
    b0 = ack_cnt[0]; b1 = ack_cnt[1];
    add_req_r = 2'b01;
    for (int k = 0; k < 5; k++) send_add(32'(k), 32'd0);
    repeat (10) @(negedge clk);
    chk("full_occ", 32'(add_occ), 32'd4);
    chk("full_req_l", 32'(add_req_l), 32'd0);
    chk("full_out0_count", 32'(ack_cnt[0] - b0), 32'd4);
    chk("full_out0_last", last_dout[0], 32'd3);
    chk("full_out1_count", 32'(ack_cnt[1] - b1), 32'd0);
    fork
      send_add(32'd5, 32'd0);
      add_req_r = 2'b11;
    join
    drain("drain_full");
    chk("stream_out0_count", 32'(ack_cnt[0] - b0), 32'd6);
    chk("stream_out1_count", 32'(ack_cnt[1] - b1), 32'd6);
    chk("stream_out0_last", last_dout[0], 32'd5);
    chk("stream_out1_last", last_dout[1], 32'd5);
`ifdef ASYNC_OP_STATS_EN
    chk("fire_count_seven", fc[0], 32'd7);
    chk("stall_seen", 32'(sc[0] != 32'd0), 32'd1);
`endif

    // 4: addi, 13 inputs wrap the depth-4 pointers
    addi_req_r = 2'b11;
    for (int k = 0; k < 13; k++) send_addi(32'(k));
    drain("drain_addi");
    chk("addi_out0_count", 32'(ack_cnt[2]), 32'd13);
    chk("addi_out1_count", 32'(ack_cnt[3]), 32'd13);
    chk("addi_out0_last", last_dout[2], 32'd14);
    chk("addi_out1_last", last_dout[3], 32'd14);

    // 5: mul and sub wraparound
    ms_req_r = 1'b1;
    send_ms(32'hFFFF_FFFF, 32'd2, 32'd1, 32'd3);
    drain("drain_ms");
    chk("mul_wrap", last_dout[4], 32'hFFFF_FFFE);
    chk("sub_wrap", last_dout[5], 32'hFFFF_FFFE);

    // 6: reset with three buffered results and one held operand
    add_req_r = 2'b00;
    send_add(32'd1, 32'd1);
    send_add(32'd2,32'd2);
    send_add(32'd3, 32'd3);
    while (add_req_l !== 2'b11) @(negedge clk);
    add_ack_l = 2'b01; add_din = {32'd0, 32'd9};
    @(negedge clk);
    add_ack_l = 2'b00;
    repeat (3) @(negedge clk);
    chk("pre_rst_occ", 32'(add_occ), 32'd3);
    chk("pre_rst_req_l", 32'(add_req_l), 32'd2);
    rst = 1'b1; add_req_r = 2'b11;
    for (int c = 0; c < 6; c++) exp_q[c].delete();
    @(negedge clk);
    chk("mid_rst_occ", 32'(add_occ), 32'd0);
    chk("mid_rst_ack_r", 32'(add_ack_r), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_l", 32'(add_req_l), 32'd3);
    chk("post_rst_ack_r", 32'(add_ack_r), 32'd0);
`ifdef ASYNC_OP_STATS_EN
    chk("post_rst_fire_count", fc[0], 32'd0);
    chk("post_rst_stall_count", sc[0], 32'd0);
`endif
    repeat (4) @(negedge clk);
    chk("post_rst_idle_occ", 32'(add_occ), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
